// File: rtl/weight_buff_sched.sv
// rtl/weight_buff_sched.sv - sequencer for one weight buffer: flush-load once, then replay per pass request
// A load is accepted only when the kernel fits the buffer; each accepted pass streams kernel_size^2 beats.
module weight_buff_sched #(
  parameter int BUFFER_DEPTH = 16,
  parameter int KS_WIDTH     = 8,
  parameter int PASS_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [KS_WIDTH-1:0]   kernel_size,
  input  logic [PASS_WIDTH-1:0] num_passes,
  input  logic                  load_start,
  input  logic                  pass_req,
  output logic                  pass_ack,
  output logic                  pass_done,
  output logic                  buf_flush,
  input  logic                  buf_flush_busy,
  output logic                  buf_en,
  input  logic                  buf_read_valid,
  output logic [KS_WIDTH-1:0]   buf_kernel_size,
  output logic                  weights_ready,
  output logic                  busy,
  output logic                  cfg_err
);

  localparam int KK_W   = 2 * KS_WIDTH;
  localparam int BEAT_W = $clog2(BUFFER_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FLUSH     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    READY     = 3'd4,
    STREAM    = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [KS_WIDTH-1:0]   ks_q;
  logic [PASS_WIDTH-1:0] np_q;
  logic [PASS_WIDTH-1:0] pass_cnt;
  logic [BEAT_W-1:0]     beat_cnt;
  logic                  err_q;

  logic [KK_W-1:0] kk_req;
  logic [KK_W-1:0] kk_cur;
  logic            cfg_ok;
  logic            idle_or_ready;
  logic            load_acc;
  logic            pass_go;
  logic            last_beat;
  logic            budget_spent;

  // Squares are formed at double width so oversized kernels can never alias into range.
  assign kk_req        = KK_W'(kernel_size) * KK_W'(kernel_size);
  assign kk_cur        = KK_W'(ks_q) * KK_W'(ks_q);
  assign cfg_ok        = (kk_req != '0) && (kk_req <= KK_W'(BUFFER_DEPTH));
  assign idle_or_ready = (state == IDLE) || (state == READY);
  assign load_acc      = idle_or_ready && load_start;
  assign pass_go       = (state == READY) && pass_req && !load_start;
  assign last_beat     = (state == STREAM) && buf_read_valid &&
                         ((KK_W'(beat_cnt) + KK_W'(1)) == kk_cur);
  assign budget_spent  = (np_q != '0) && ((pass_cnt + PASS_WIDTH'(1)) == np_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (load_start && cfg_ok) state_nxt = FLUSH;
      FLUSH:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (buf_flush_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!buf_flush_busy) state_nxt = READY;
      READY: begin
        if (load_start && cfg_ok) state_nxt = FLUSH;
        else if (pass_go)         state_nxt = STREAM;
      end
      STREAM:    if (last_beat) state_nxt = budget_spent ? IDLE : READY;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ks_q     <= '0;
      np_q     <= '0;
      pass_cnt <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (load_acc) begin
        err_q <= !cfg_ok;
        if (cfg_ok) begin
          ks_q     <= kernel_size;
          np_q     <= num_passes;
          pass_cnt <= '0;
        end
      end
      if (pass_go)
        beat_cnt <= '0;
      else if ((state == STREAM) && buf_read_valid)
        beat_cnt <= beat_cnt + BEAT_W'(1);
      if (last_beat)
        pass_cnt <= pass_cnt + PASS_WIDTH'(1);
    end
  end

  assign pass_ack        = pass_go;
  assign buf_en          = pass_go;
  assign pass_done       = last_beat;
  assign buf_flush       = (state == FLUSH);
  assign buf_kernel_size = ks_q;
  assign weights_ready   = (state == READY);
  assign busy            = !idle_or_ready;
  assign cfg_err         = err_q;

endmodule

// File: tb/tb_weight_buff_sched.sv
// tb/tb_weight_buff_sched.sv - directed and randomized checks of weight_buff_sched against a behavioural model
module tb_weight_buff_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] kernel_size;
  logic [7:0] num_passes;
  logic       load_start, pass_req, buf_flush_busy, buf_read_valid;
  logic       pass_ack, pass_done, buf_flush, buf_en, weights_ready, busy, cfg_err;
  logic [7:0] buf_kernel_size;

  int n_checks = 0;
  int n_pass   = 0;

  weight_buff_sched #(.BUFFER_DEPTH(16), .KS_WIDTH(8), .PASS_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .kernel_size(kernel_size), .num_passes(num_passes),
    .load_start(load_start), .pass_req(pass_req), .pass_ack(pass_ack), .pass_done(pass_done),
    .buf_flush(buf_flush), .buf_flush_busy(buf_flush_busy), .buf_en(buf_en),
    .buf_read_valid(buf_read_valid), .buf_kernel_size(buf_kernel_size),
    .weights_ready(weights_ready), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: what the controller is doing, tracked as remaining work.
  localparam int PH_EMPTY = 0, PH_FLUSH = 1, PH_BUSY_HI = 2, PH_BUSY_LO = 3, PH_LOADED = 4, PH_STREAM = 5;
  int m_phase = PH_EMPTY;
  int m_ks = 0, m_passes_left = 0, m_beats_left = 0;
  bit m_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    logic [14:0] exp_v, act_v;
    bit ready, ack;
    int kk;
    ready = rstn && (m_phase == PH_LOADED);
    ack   = ready && pass_req && !load_start;
    if (!rstn) exp_v = '0;
    else exp_v = {ack,
                  (m_phase == PH_STREAM) && buf_read_valid && (m_beats_left == 1),
                  m_phase == PH_FLUSH, ack, ready,
                  m_phase != PH_EMPTY && m_phase != PH_LOADED,
                  m_err, 8'(m_ks)};
    act_v = {pass_ack, pass_done, buf_flush, buf_en, weights_ready, busy, cfg_err, buf_kernel_size};
    n_checks++;
    if (act_v !== exp_v) $display("FAIL model_outputs @%0t: got %h expected %h", $time, act_v, exp_v);
    else n_pass++;
    if (!rstn) begin
      m_phase = PH_EMPTY; m_ks = 0; m_passes_left = 0; m_beats_left = 0; m_err = 0;
    end else begin
      case (m_phase)
        PH_EMPTY, PH_LOADED: begin
          if (load_start) begin
            kk = int'(kernel_size) * int'(kernel_size);
            if (kk == 0 || kk > 16) m_err = 1;
            else begin
              m_err = 0; m_ks = kernel_size;
              m_passes_left = (num_passes == 0) ? -1 : int'(num_passes);
              m_phase = PH_FLUSH;
            end
          end else if (ack) begin
            m_beats_left = m_ks * m_ks;
            m_phase = PH_STREAM;
          end
        end
        PH_FLUSH:   m_phase = PH_BUSY_HI;
        PH_BUSY_HI: if (buf_flush_busy) m_phase = PH_BUSY_LO;
        PH_BUSY_LO: if (!buf_flush_busy) m_phase = PH_LOADED;
        PH_STREAM: if (buf_read_valid) begin
          m_beats_left--;
          if (m_beats_left == 0) begin
            if (m_passes_left > 0) m_passes_left--;
            m_phase = (m_passes_left == 0) ? PH_EMPTY : PH_LOADED;
          end
        end
        default: m_phase = PH_EMPTY;
      endcase
    end
  end

  // Tasks start and end just after a rising edge, except where noted.
  task automatic flush_handshake();
    int i;
    @(posedge clk); #1 buf_flush_busy = 1;
    @(negedge clk);
    chk("flush_one_cycle", buf_flush, 0);
    chk("busy_during_flush", busy, 1);
    repeat (2) @(posedge clk);
    #1 buf_flush_busy = 0;
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (weights_ready) break;
    end
    chk("ready_after_flush", weights_ready, 1);   // ends at a falling edge
  endtask

  task automatic do_load(input int ks, input int np);
    kernel_size = 8'(ks); num_passes = 8'(np); load_start = 1;
    @(posedge clk); #1 load_start = 0;
    @(negedge clk);
    chk("flush_pulse", buf_flush, 1);
    chk("latched_ks", buf_kernel_size, ks);
    chk("err_cleared", cfg_err, 0);
    flush_handshake();
    chk("ready_not_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  // Called just after a falling edge on which pass_ack was seen.
  task automatic stream_beats(input int ls_beat, output int done_beat);
    int beats = 0;
    done_beat = 0;
    @(posedge clk); #1 pass_req = 0; buf_read_valid = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      beats++;
      if (pass_done) begin done_beat = beats; break; end
      @(posedge clk); #1 load_start = (beats == ls_beat);
    end
    @(posedge clk); #1 buf_read_valid = 0; load_start = 0;
  endtask

  task automatic do_pass(input int exp_kk, input int ls_beat);
    int done_beat, acks;
    bit got;
    got = 0;
    pass_req = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pass_ack) begin got = 1; break; end
    end
    chk("pass_ack_seen", got, 1);
    chk("buf_en_with_ack", buf_en, 1);
    stream_beats(ls_beat, done_beat);
    chk("pass_done_beat", done_beat, exp_kk);
  endtask

  task automatic count_acks(input int n, output int acks);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); acks += pass_ack;
      @(posedge clk); #1;
    end
  endtask

  task automatic bad_load(input int ks, input string name);
    kernel_size = 8'(ks); load_start = 1;
    @(posedge clk); #1 load_start = 0;
    @(negedge clk);
    chk({name, "_err"}, cfg_err, 1);
    chk({name, "_noflush"}, buf_flush, 0);
    chk({name, "_notbusy"}, busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acks, done_beat;
    bit acked;
    rstn = 0; kernel_size = 0; num_passes = 0; load_start = 0; pass_req = 0;
    buf_flush_busy = 0; buf_read_valid = 0;
    @(negedge clk);
    chk("reset_outputs", int'({pass_ack, pass_done, buf_flush, buf_en, weights_ready, busy, cfg_err, buf_kernel_size}), 0);
    @(posedge clk); #1 rstn = 1;
    @(posedge clk); #1;

    do_load(3, 2);
    do_pass(9, 0);
    @(negedge clk); chk("ready_after_pass1", weights_ready, 1);
    @(posedge clk); #1;
    do_pass(9, 0);
    @(negedge clk);
    chk("idle_after_budget", weights_ready, 0);
    chk("idle_not_busy", busy, 0);
    @(posedge clk); #1 pass_req = 1;
    count_acks(5, acks);
    chk("no_ack_in_idle", acks, 0);
    pass_req = 0;

    bad_load(5, "ks5");
    bad_load(0, "ks0");
    bad_load(255, "ks255");
    do_load(4, 0);
    do_pass(16, 0);

    // load_start and pass_req together in READY: reload first
    kernel_size = 3; num_passes = 0; load_start = 1; pass_req = 1;
    @(negedge clk); chk("load_wins_ack", pass_ack, 0);
    @(posedge clk); #1 load_start = 0;
    @(negedge clk); chk("load_wins_flush", buf_flush, 1);
    flush_handshake();
    chk("pending_ack_after_reload", pass_ack, 1);
    stream_beats(0, done_beat);
    chk("reload_pass_beat", done_beat, 9);

    kernel_size = 2;
    do_pass(9, 3);
    @(negedge clk);
    chk("stream_load_ignored_ks", buf_kernel_size, 3);
    chk("stream_load_no_err", cfg_err, 0);
    @(posedge clk); #1;

    // reset after 4 beats of a pass
    pass_req = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pass_ack) break;
    end
    @(posedge clk); #1 pass_req = 0; buf_read_valid = 1;
    repeat (4) @(posedge clk);
    #1 rstn = 0;
    @(negedge clk);
    chk("midstream_reset", int'({pass_ack, pass_done, buf_flush, buf_en, weights_ready, busy, cfg_err, buf_kernel_size}), 0);
    @(posedge clk); #1 rstn = 1; buf_read_valid = 0; pass_req = 1;
    count_acks(6, acks);
    chk("no_ack_after_reset", acks, 0);
    pass_req = 0;
    do_load(2, 1);
    do_pass(4, 0);

    for (int c = 0; c < 4000; c++) begin
      int r;
      @(negedge clk); acked = pass_ack;
      @(posedge clk); #1;
      rstn = (rstn == 0) ? 1'b1 : ($urandom % 600 != 0);
      if (acked) pass_req = 0;
      else if (!pass_req) pass_req = ($urandom % 4 == 0);
      load_start = ($urandom % 25 == 0);
      r = $urandom % 10;
      kernel_size = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : (r == 2) ? 8'd17 : 8'(1 + $urandom % 4);
      num_passes = 8'($urandom % 4);
      buf_read_valid = ($urandom % 3 != 0);
      buf_flush_busy = $urandom % 2;
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
